// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse constants, controller states and the bring-up step ROM.
// The step ROM is pure combinational lookup and has no latency.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SEND,
    ST_WAIT_RSP,
    ST_STREAM,
    ST_FAIL
  } ctrl_state_t;

  // First byte of a stream packet, minus the always-one sync bit.
  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic       y_sign;
    logic       x_sign;
    logic [2:0] btn;
  } pkt_hdr_t;

  function automatic logic [7:0] step_cmd(input logic [1:0] step, input logic [7:0] rate);
    logic [7:0] cmd;
    case (step)
      2'd0:    cmd = CMD_RESET;
      2'd1:    cmd = CMD_SET_RATE;
      2'd2:    cmd = rate;
      default: cmd = CMD_ENABLE;
    endcase
    return cmd;
  endfunction

  function automatic logic [7:0] step_rsp(input logic [1:0] step, input logic [1:0] idx);
    logic [7:0] rsp;
    rsp = RSP_ACK;
    if (step == 2'd0) begin
      case (idx)
        2'd1:    rsp = RSP_BAT_OK;
        2'd2:    rsp = RSP_ID;
        default: rsp = RSP_ACK;
      endcase
    end
    return rsp;
  endfunction

  function automatic logic [1:0] step_last_idx(input logic [1:0] step);
    return (step == 2'd0) ? 2'd2 : 2'd0;
  endfunction

endpackage

// File: rtl/ps2_pkt_assembler.sv
// Frames 3-byte PS/2 stream packets into buttons and 9-bit signed deltas.
// pkt_valid pulses one cycle after the third byte; no backpressure, bytes arrive at the PHY's pace.
module ps2_pkt_assembler
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       pkt_valid,
  output logic [2:0] pkt_status,
  output logic [8:0] pkt_dx,
  output logic [8:0] pkt_dy
);

  logic [1:0] idx;
  pkt_hdr_t   hdr;
  logic [7:0] b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= 2'd0;
      hdr        <= '0;
      b1         <= 8'd0;
      pkt_valid  <= 1'b0;
      pkt_status <= 3'd0;
      pkt_dx     <= 9'd0;
      pkt_dy     <= 9'd0;
    end else begin
      pkt_valid <= 1'b0;
      if (!en) begin
        idx <= 2'd0;
      end else if (rx_valid) begin
        case (idx)
          2'd0: begin
            // Bit 3 is always set in a genuine header; anything else is resync noise.
            if (rx_byte[3]) begin
              hdr <= pkt_hdr_t'({rx_byte[7:4], rx_byte[2:0]});
              idx <= 2'd1;
            end
          end
          2'd1: begin
            b1  <= rx_byte;
            idx <= 2'd2;
          end
          default: begin
            idx <= 2'd0;
            if (!hdr.y_ovf && !hdr.x_ovf) begin
              pkt_valid  <= 1'b1;
              pkt_status <= hdr.btn;
              pkt_dx     <= {hdr.x_sign, b1};
              pkt_dy     <= {hdr.y_sign, rx_byte};
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse bring-up sequencer with resend/timeout retries, then packet streaming.
// One byte in flight: tx_req holds until tx_done; responses are consumed as they arrive.
module ps2_mouse_ctrl
  import ps2_pkg::*;
#(
  parameter logic [19:0] TIMEOUT     = 20'd500000,
  parameter logic [1:0]  MAX_RETRY   = 2'd2,
  parameter logic [7:0]  SAMPLE_RATE = 8'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reinit,
  output logic       tx_req,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       pkt_valid,
  output logic [2:0] pkt_status,
  output logic [8:0] pkt_dx,
  output logic [8:0] pkt_dy,
  output logic       ready,
  output logic       err
);

  ctrl_state_t state, state_d;
  logic [1:0]  step, step_d;
  logic [1:0]  rsp_idx, rsp_idx_d;
  logic [1:0]  retry, retry_d;
  logic [19:0] tmo_cnt;
  logic        cnt_clr;
  logic [2:0]  retry_inc;
  logic        retry_over;
  logic        timeout;

  assign retry_inc  = {1'b0, retry} + 3'd1;
  assign retry_over = retry_inc > {1'b0, MAX_RETRY};
  assign timeout    = (tmo_cnt == TIMEOUT - 20'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_LOAD;
      step    <= 2'd0;
      rsp_idx <= 2'd0;
      retry   <= 2'd0;
    end else begin
      state   <= state_d;
      step    <= step_d;
      rsp_idx <= rsp_idx_d;
      retry   <= retry_d;
    end
  end

  always_comb begin
    state_d   = state;
    step_d    = step;
    rsp_idx_d = rsp_idx;
    retry_d   = retry;
    cnt_clr   = 1'b0;
    if (reinit) begin
      state_d = ST_LOAD;
      step_d  = 2'd0;
      retry_d = 2'd0;
    end else begin
      case (state)
        ST_LOAD: state_d = ST_SEND;
        ST_SEND: begin
          if (tx_req && tx_done) begin
            state_d   = ST_WAIT_RSP;
            rsp_idx_d = 2'd0;
            cnt_clr   = 1'b1;
          end
        end
        ST_WAIT_RSP: begin
          if (rx_valid) begin
            cnt_clr = 1'b1;
            if (rx_byte == step_rsp(step, rsp_idx)) begin
              if (rsp_idx == step_last_idx(step)) begin
                if (step == 2'd3) begin
                  state_d = ST_STREAM;
                end else begin
                  step_d  = step + 2'd1;
                  state_d = ST_LOAD;
                end
              end else begin
                rsp_idx_d = rsp_idx + 2'd1;
              end
            end else if (rx_byte == RSP_RESEND) begin
              retry_d = retry_inc[1:0];
              state_d = retry_over ? ST_FAIL : ST_SEND;
            end else begin
              retry_d = retry_inc[1:0];
              step_d  = 2'd0;
              state_d = retry_over ? ST_FAIL : ST_LOAD;
            end
          end else if (timeout) begin
            retry_d = retry_inc[1:0];
            step_d  = 2'd0;
            state_d = retry_over ? ST_FAIL : ST_LOAD;
          end
        end
        ST_STREAM, ST_FAIL: ;
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // Counter idles at zero outside WAIT_RSP so every entry starts a fresh window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 20'd0;
    end else if (cnt_clr || state != ST_WAIT_RSP) begin
      tmo_cnt <= 20'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 20'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_req  <= 1'b0;
      tx_byte <= 8'd0;
    end else begin
      if (state == ST_LOAD) begin
        tx_byte <= step_cmd(step, SAMPLE_RATE);
      end
      tx_req <= (state == ST_SEND) && !(tx_req && tx_done) && !reinit;
    end
  end

  assign ready = (state == ST_STREAM);
  assign err   = (state == ST_FAIL);

  ps2_pkt_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .en         ((state == ST_STREAM) && !reinit),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .pkt_valid  (pkt_valid),
    .pkt_status (pkt_status),
    .pkt_dx     (pkt_dx),
    .pkt_dy     (pkt_dy)
  );

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Bench for ps2_mouse_ctrl: a scripted mouse device answers commands, packets are
// checked from a vector table and from random byte streams against a framing model.
module tb_ps2_mouse_ctrl;

  localparam logic [19:0] TMO = 20'd64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reinit = 1'b0;
  logic       tx_req;
  logic [7:0] tx_byte;
  logic       tx_done = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       pkt_valid;
  logic [2:0] pkt_status;
  logic [8:0] pkt_dx;
  logic [8:0] pkt_dy;
  logic       ready;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Last valid packet as the bench expects it to be held on pkt_*.
  int m_st = 0;
  int m_dx = 0;
  int m_dy = 0;

  ps2_mouse_ctrl #(
    .TIMEOUT     (TMO),
    .MAX_RETRY   (2'd2),
    .SAMPLE_RATE (8'd100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reinit     (reinit),
    .tx_req     (tx_req),
    .tx_byte    (tx_byte),
    .tx_done    (tx_done),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .pkt_valid  (pkt_valid),
    .pkt_status (pkt_status),
    .pkt_dx     (pkt_dx),
    .pkt_dy     (pkt_dy),
    .ready      (ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       has_lead;
    logic [7:0] lead;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic       exp_vld;
    int         st;
    int         dx;
    int         dy;
  } pvec_t;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Called and returns at a negedge; the byte is captured by the posedge in between.
  task automatic rx_send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int max);
    repeat ($urandom_range(0, max)) @(negedge clk);
  endtask

  task automatic wait_tx(input logic [7:0] exp, input string nm);
    int n;
    n = 0;
    while (tx_req !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: tx_req never rose, expected byte %0h", nm, exp);
    end else begin
      chk({nm, "_byte"}, tx_byte, exp);
      gap(2);
      chk({nm, "_hold"}, tx_byte, exp);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk({nm, "_drop"}, tx_req, 1'b0);
    end
  endtask

  task automatic bring_up(input bit resend_f3);
    wait_tx(8'hFF, "bu_ff");
    gap(4); rx_send(8'hFA);
    gap(4); rx_send(8'hAA);
    gap(4); rx_send(8'h00);
    wait_tx(8'hF3, "bu_f3");
    if (resend_f3) begin
      gap(4); rx_send(8'hFE);
      wait_tx(8'hF3, "bu_f3_again");
    end
    gap(4); rx_send(8'hFA);
    wait_tx(8'h64, "bu_rate");
    gap(4); rx_send(8'hFA);
    wait_tx(8'hF4, "bu_f4");
    chk("bu_ready_before", ready, 1'b0);
    gap(4); rx_send(8'hFA);
    chk("bu_ready", ready, 1'b1);
    chk("bu_err", err, 1'b0);
  endtask

  task automatic pulse_reinit();
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    pvec_t vec[8];
    logic [7:0] pend[$];
    int hi;

    vec[0] = '{1'b0, 8'h00, 8'h38, 8'h05, 8'hFB, 1'b1, 0, -251, -5};
    vec[1] = '{1'b1, 8'h02, 8'h09, 8'h01, 8'h01, 1'b1, 1, 1, 1};
    vec[2] = '{1'b0, 8'h00, 8'hC8, 8'h00, 8'h00, 1'b0, 1, 1, 1};
    vec[3] = '{1'b0, 8'h00, 8'h2F, 8'h80, 8'h7F, 1'b1, 7, 128, -129};
    vec[4] = '{1'b0, 8'h00, 8'h18, 8'hFF, 8'h00, 1'b1, 0, -1, 0};
    vec[5] = '{1'b0, 8'h00, 8'h48, 8'h01, 8'h01, 1'b0, 0, -1, 0};
    vec[6] = '{1'b0, 8'h00, 8'h88, 8'h7F, 8'h7F, 1'b0, 0, -1, 0};
    vec[7] = '{1'b1, 8'h10, 8'h3D, 8'h00, 8'h00, 1'b1, 5, -256, -256};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx_req", tx_req, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_pkt_status", pkt_status, 3'd0);
    chk("rst_pkt_dx", pkt_dx, 9'd0);
    chk("rst_pkt_dy", pkt_dy, 9'd0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;

    // LOAD then SEND, tx_req one cycle after SEND is entered
    @(negedge clk);
    chk("lat_tx_req_low", tx_req, 1'b0);
    chk("lat_tx_byte", tx_byte, 8'hFF);
    @(negedge clk);
    chk("lat_tx_req_high", tx_req, 1'b1);

    bring_up(1'b0);

    // Packet vector table
    for (int i = 0; i < 8; i++) begin
      if (vec[i].has_lead) begin
        rx_send(vec[i].lead);
        chk("tbl_lead_vld", pkt_valid, 1'b0);
      end
      rx_send(vec[i].b0);
      rx_send(vec[i].b1);
      gap(2);
      rx_send(vec[i].b2);
      chk($sformatf("tbl%0d_vld", i), pkt_valid, vec[i].exp_vld);
      chk($sformatf("tbl%0d_st", i), pkt_status, vec[i].st);
      chk($sformatf("tbl%0d_dx", i), $signed(pkt_dx), vec[i].dx);
      chk($sformatf("tbl%0d_dy", i), $signed(pkt_dy), vec[i].dy);
      @(negedge clk);
      chk($sformatf("tbl%0d_pulse", i), pkt_valid, 1'b0);
    end
    m_st = 5; m_dx = -256; m_dy = -256;

    // Random byte stream against the framing model
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      logic [7:0] h;
      logic       ev;
      b  = 8'($urandom_range(0, 255));
      ev = 1'b0;
      if (pend.size() != 0 || b[3]) pend.push_back(b);
      if (pend.size() == 3) begin
        h = pend[0];
        if (h[7:6] == 2'b00) begin
          ev   = 1'b1;
          m_st = int'(h[2:0]);
          m_dx = int'(pend[1]) - (h[4] ? 256 : 0);
          m_dy = int'(pend[2]) - (h[5] ? 256 : 0);
        end
        pend.delete();
      end
      rx_send(b);
      chk("rnd_vld", pkt_valid, ev);
      chk("rnd_st", pkt_status, m_st);
      chk("rnd_dx", $signed(pkt_dx), m_dx);
      chk("rnd_dy", $signed(pkt_dy), m_dy);
      gap(2);
    end

    // Partial packet, then reinit coincident with a byte in STREAM
    rx_send(8'h08);
    reinit   = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h01;
    @(negedge clk);
    reinit   = 1'b0;
    rx_valid = 1'b0;
    chk("reinit_ready", ready, 1'b0);
    chk("reinit_err", err, 1'b0);

    bring_up(1'b1);

    // Partial packet from before reinit must be gone
    rx_send(8'h09);
    rx_send(8'h01);
    rx_send(8'h01);
    chk("post_vld", pkt_valid, 1'b1);
    chk("post_st", pkt_status, 1);
    chk("post_dx", $signed(pkt_dx), 1);
    chk("post_dy", $signed(pkt_dy), 1);

    // reinit during WAIT_RSP of step 2 with a coincident FA
    pulse_reinit();
    wait_tx(8'hFF, "r2_ff");
    rx_send(8'hFA); rx_send(8'hAA); rx_send(8'h00);
    wait_tx(8'hF3, "r2_f3");
    rx_send(8'hFA);
    wait_tx(8'h64, "r2_rate");
    gap(3);
    reinit   = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'hFA;
    @(negedge clk);
    reinit   = 1'b0;
    rx_valid = 1'b0;
    chk("r2_ready", ready, 1'b0);
    chk("r2_err", err, 1'b0);
    wait_tx(8'hFF, "r2_restart");

    // Silent device: FF three times in total, then failure
    wait_tx(8'hFF, "tmo_retry1");
    wait_tx(8'hFF, "tmo_retry2");
    hi = 0;
    while (err !== 1'b1 && hi < 400) begin
      @(negedge clk);
      hi++;
    end
    chk("tmo_err", err, 1'b1);
    chk("tmo_ready", ready, 1'b0);
    chk("tmo_tx_req", tx_req, 1'b0);
    hi = 0;
    for (int i = 0; i < 150; i++) begin
      if (i == 10) rx_send(8'hFA);
      else @(negedge clk);
      if (tx_req === 1'b1) hi++;
    end
    chk("fail_no_tx", hi, 0);
    chk("fail_err_sticky", err, 1'b1);
    chk("fail_ready", ready, 1'b0);

    // reinit clears the failure and the sequence runs again
    pulse_reinit();
    chk("clr_err", err, 1'b0);
    bring_up(1'b0);
    rx_send(8'h38);
    rx_send(8'h05);
    rx_send(8'hFB);
    chk("fin_vld", pkt_valid, 1'b1);
    chk("fin_dx", $signed(pkt_dx), -251);
    chk("fin_dy", $signed(pkt_dy), -5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_ctrl.md
# ps2_mouse_ctrl

Host-side initialisation and packet controller for the PS/2 mouse port. It sits between the byte-level PS/2 PHY (transmit/receive serialisers) and the memory-mapped mouse register block. After reset it runs the mouse bring-up command sequence, handling acknowledgements, resend requests, timeouts and bounded retries. It then assembles 3-byte stream packets into signed movement deltas and button status.

## Interface
Parameters:
- TIMEOUT, 20'd500000: clk cycles to wait for each response byte before declaring a timeout.
- MAX_RETRY, 2'd2: sequence restarts allowed before declaring failure.
- SAMPLE_RATE, 8'd100: argument sent with the set-sample-rate command.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- reinit  in  1  one-cycle pulse; restart the bring-up sequence.
- tx_req  out  1  request the PHY to transmit tx_byte.
- tx_byte  out  8  byte to transmit.
- tx_done  in  1  one-cycle pulse from the PHY when the byte is sent and the device has acked at line level.
- rx_valid  in  1  one-cycle pulse when rx_byte holds a received byte.
- rx_byte  in  8  received byte.
- pkt_valid  out  1  one-cycle pulse; new packet on pkt_*.
- pkt_status  out  3  {middle, right, left} buttons.
- pkt_dx  out  9  signed X delta, two's complement.
- pkt_dy  out  9  signed Y delta, two's complement.
- ready  out  1  bring-up complete; streaming.
- err  out  1  sticky; bring-up failed.

## Operation
- Sequence step ROM, 4 steps:
  - step 0: send FF; expect FA, AA, 00.
  - step 1: send F3; expect FA.
  - step 2: send SAMPLE_RATE; expect FA.
  - step 3: send F4; expect FA.
- Controller states:
  - LOAD: set tx_byte from the step ROM; go to SEND.
  - SEND: tx_req=1 until tx_done; go to WAIT_RSP, clear the response index and the timeout counter.
  - WAIT_RSP: compare each rx byte with the expected byte at the response index.
    - Match: advance the index. After the last expected byte, go to the next step's LOAD. After step 3, go to STREAM.
    - FE (resend): return to SEND with the same byte; counts as one retry.
    - Any other byte, or a timeout: go to step 0 LOAD; retry+1.
  - Retry exceeding MAX_RETRY: go to FAIL.
  - STREAM: ready=1; bytes are routed to the packet assembler.
  - FAIL: err=1, tx_req=0; all rx bytes are ignored.
- reinit in any state: the next state is step 0 LOAD with retry=0, ready=0, err=0. reinit wins over a simultaneous rx_valid or tx_done.
- Packet assembly (STREAM only), byte index 0..2:
  - A byte at index 0 with bit3=0 is discarded and the index stays 0 (resync).
  - On the third byte: pkt_status=b0[2:0], pkt_dx={b0[4],b1}, pkt_dy={b0[5],b2}.
  - pkt_valid pulses only if b0[7:6]==0; an overflow packet is dropped silently. The index returns to 0 in both cases.
- rx_valid outside WAIT_RSP and STREAM is ignored.

## Timing
- Reset values: tx_req=0, tx_byte=0, pkt_valid=0, pkt_status=0, pkt_dx=0, pkt_dy=0, ready=0, err=0. The state is step 0 LOAD, retry=0, so bring-up starts on the first clk after reset deasserts.
- LOAD→SEND takes 1 cycle. tx_req rises 1 cycle after entering SEND. tx_byte is stable whenever tx_req=1. tx_req falls in the cycle after tx_done.
- Timeout counter: cleared on WAIT_RSP entry and on every rx_valid. Timeout fires when the count reaches TIMEOUT-1 with no rx_valid.
- rx_valid and timeout in the same cycle: the byte is processed and the timeout is ignored.
- pkt_valid is asserted in the cycle after the third byte's rx_valid. pkt_* hold their values until the next valid packet.
- ready rises in the cycle after the final FA is accepted. ready falls in the cycle after reinit.
- rst mid-sequence or mid-packet: all state is abandoned immediately. Partial packets and partial responses are lost.

## Structure
- Shared package ps2_pkg holds:
  - Command constants: CMD_RESET FF, CMD_SET_RATE F3, CMD_ENABLE F4.
  - Response constants: RSP_ACK FA, RSP_RESEND FE, RSP_BAT_OK AA, RSP_ID 00.
  - The controller state enum.
- One sub-module, ps2_pkt_assembler. It receives rx_valid/rx_byte plus an enable from STREAM and drives the pkt_* outputs.

## Test plan
- Clean bring-up: device replies FA,AA,00 / FA / FA / FA → tx_byte sequence FF,F3,64,F4; ready=1 one cycle after the last FA; err=0.
- Resend: device answers the first F3 with FE, then FA → F3 is transmitted twice; the sequence completes; ready=1.
- Timeout: no reply to FF for TIMEOUT cycles on every attempt → FF is sent 3 times, then err=1, ready=0, tx_req=0.
- Packet: bytes 38,05,FB → pkt_valid pulse with pkt_status=0, pkt_dx=-251 (9'h105), pkt_dy=-5 (9'h1FB).
- Resync and overflow: bytes 02 then 09,01,01 → one packet with pkt_status=1, pkt_dx=1, pkt_dy=1. Then C8,00,00 → no pkt_valid.
- reinit asserted during WAIT_RSP of step 2, coincident with rx FA → the FA is ignored; the next tx_byte is FF; ready=0; err=0.
